// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types for the register-file read-port arbiter between decode and debug.
package regfile_read_arbiter_pkg;

  typedef logic [4:0]  register_id_t;
  typedef logic [31:0] int_t;

  typedef struct packed {
    register_id_t id1;
    register_id_t id2;
  } register_read_id_t;

  typedef struct packed {
    int_t data1;
    int_t data2;
  } register_data_read_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Decode, debug and register-file read signals seen by the arbiter.
interface regfile_read_arbiter_if;
  import regfile_read_arbiter_pkg::*;

  logic                decodeWantsRead;
  register_read_id_t   decodeRegReadId;
  register_data_read_t decodeRegData;
  logic                decodeBlocked;

  logic                dbgReqValid;
  logic                dbgReqReady;
  register_read_id_t   dbgReqId;
  logic                dbgRespValid;
  logic                dbgRespReady;
  register_data_read_t dbgRespData;

  register_read_id_t   regReadId;
  register_data_read_t regDataRead;

  // The arbiter is the slave; decode, debug and the register file form the master side.
  modport slave (
    input  decodeWantsRead, decodeRegReadId, dbgReqValid, dbgReqId,
           dbgRespReady, regDataRead,
    output decodeRegData, decodeBlocked, dbgReqReady, dbgRespValid,
           dbgRespData, regReadId
  );

  modport master (
    output decodeWantsRead, decodeRegReadId, dbgReqValid, dbgReqId,
           dbgRespReady, regDataRead,
    input  decodeRegData, decodeBlocked, dbgReqReady, dbgRespValid,
           dbgRespData, regReadId
  );

endinterface

// File: rtl/regfile_read_arbiter_starve_counter.sv
// Saturating wait counter for a pending debug read; flags when the starvation limit is reached.
module regfile_read_arbiter_starve_counter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  output logic atLimit
);

  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

  logic [COUNT_WIDTH-1:0] waitCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCount <= '0;
    end else if (clear) begin
      waitCount <= '0;
    end else if (increment && (waitCount != '1)) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  assign atLimit = (waitCount >= LIMIT);

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's two read ports between decode (default owner) and a debug
// requester; a starving debug read is forced through by blocking decode for one cycle.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int COUNT_WIDTH  = 8
) (
  input logic                  clock,
  input logic                  reset,
  regfile_read_arbiter_if.slave bus
);

  arb_state_t          state;
  logic                respValid_p1;
  register_data_read_t respData_p1;

  logic pending;
  logic freeGrant;
  logic forcedGrant;
  logic grant;
  logic atLimit;

  // Grant logic is gated by reset so the ports fall back to decode while reset is held.
  always_comb begin
    pending     = reset && bus.dbgReqValid && ((state == IDLE) || (state == WAIT));
    freeGrant   = pending && !bus.decodeWantsRead;
    forcedGrant = pending && bus.decodeWantsRead && atLimit;
    grant       = freeGrant || forcedGrant;
  end

  regfile_read_arbiter_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_starve_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (grant || !bus.dbgReqValid),
    .increment (pending && !grant),
    .atLimit   (atLimit)
  );

  assign bus.dbgReqReady   = grant;
  assign bus.decodeBlocked = forcedGrant;
  assign bus.regReadId     = grant ? bus.dbgReqId : bus.decodeRegReadId;
  assign bus.decodeRegData = grant ? '0 : bus.regDataRead;
  assign bus.dbgRespValid  = respValid_p1;
  assign bus.dbgRespData   = respData_p1;

  // Stage p1: response captured on the grant edge, held until the consumer accepts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      respValid_p1 <= 1'b0;
      respData_p1  <= '0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (grant) begin
            state        <= RESP;
            respValid_p1 <= 1'b1;
            respData_p1  <= bus.regDataRead;
          end else if (bus.dbgReqValid) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        RESP: begin
          if (bus.dbgRespReady) begin
            state        <= IDLE;
            respValid_p1 <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          respValid_p1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: vector table plus multi-cycle corner sequences.
module tb_regfile_read_arbiter;
  import regfile_read_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_read_arbiter_if bus();

  regfile_read_arbiter #(
    .STARVE_LIMIT (8),
    .COUNT_WIDTH  (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int_t rf [32];
  assign bus.regDataRead = {rf[bus.regReadId.id1], rf[bus.regReadId.id2]};

  int checks = 0;
  int errors = 0;

  function automatic register_read_id_t ids(input int a, input int b);
    ids.id1 = register_id_t'(a);
    ids.id2 = register_id_t'(b);
  endfunction

  function automatic register_data_read_t rd(input register_read_id_t r);
    return {rf[r.id1], rf[r.id2]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic dv, input logic rr,
                      input register_read_id_t dbg, input register_read_id_t dec);
    @(negedge clock);
    bus.decodeWantsRead = w;
    bus.dbgReqValid     = dv;
    bus.dbgRespReady    = rr;
    bus.dbgReqId        = dbg;
    bus.decodeRegReadId = dec;
    #4;
  endtask

  // Checks every output for the current cycle against the expected grant/block/response.
  task automatic expect_cycle(input string tag, input logic eReady, input logic eBlk,
                              input logic eRespV, input register_read_id_t respIds);
    chk({tag, ".ready"},   64'(bus.dbgReqReady),   64'(eReady));
    chk({tag, ".blocked"}, 64'(bus.decodeBlocked), 64'(eBlk));
    chk({tag, ".regId"},   64'(bus.regReadId),
        64'(eReady ? bus.dbgReqId : bus.decodeRegReadId));
    chk({tag, ".decData"}, 64'(bus.decodeRegData),
        eReady ? 64'h0 : 64'(rd(bus.decodeRegReadId)));
    chk({tag, ".respV"},   64'(bus.dbgRespValid),  64'(eRespV));
    if (eRespV) chk({tag, ".respData"}, 64'(bus.dbgRespData), 64'(rd(respIds)));
  endtask

  typedef struct {
    logic              w;
    logic              dv;
    logic              rr;
    register_read_id_t dbg;
    logic              eReady;
    logic              eBlk;
    logic              eRespV;
    register_read_id_t eRespIds;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | i;
    rf[0] = 32'h0;
    rf[3] = 32'h11;
    rf[5] = 32'h22;

    // Reset with a grantable request present: nothing may be granted.
    reset               = 1'b0;
    bus.decodeWantsRead = 1'b0;
    bus.dbgReqValid     = 1'b1;
    bus.dbgRespReady    = 1'b0;
    bus.dbgReqId        = ids(3, 5);
    bus.decodeRegReadId = ids(1, 2);
    #12;
    chk("rst.ready",    64'(bus.dbgReqReady),   64'h0);
    chk("rst.blocked",  64'(bus.decodeBlocked), 64'h0);
    chk("rst.respV",    64'(bus.dbgRespValid),  64'h0);
    chk("rst.respData", 64'(bus.dbgRespData),   64'h0);
    chk("rst.regId",    64'(bus.regReadId),     64'(ids(1, 2)));
    bus.dbgReqValid = 1'b0;
    #1 reset = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 1'b0, ids(3, 5), 1'b1, 1'b0, 1'b0, ids(0, 0)};
    vecs[1] = '{1'b1, 1'b0, 1'b0, ids(3, 5), 1'b0, 1'b0, 1'b1, ids(3, 5)};
    vecs[2] = '{1'b1, 1'b0, 1'b1, ids(3, 5), 1'b0, 1'b0, 1'b1, ids(3, 5)};
    vecs[3] = '{1'b0, 1'b0, 1'b0, ids(3, 5), 1'b0, 1'b0, 1'b0, ids(0, 0)};
    vecs[4] = '{1'b0, 1'b1, 1'b0, ids(7, 0), 1'b1, 1'b0, 1'b0, ids(0, 0)};
    vecs[5] = '{1'b1, 1'b1, 1'b1, ids(7, 0), 1'b0, 1'b0, 1'b1, ids(7, 0)};
    vecs[6] = '{1'b0, 1'b0, 1'b0, ids(7, 0), 1'b0, 1'b0, 1'b0, ids(0, 0)};
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].w, vecs[i].dv, vecs[i].rr, vecs[i].dbg, ids(1, 2));
      expect_cycle($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eBlk,
                   vecs[i].eRespV, vecs[i].eRespIds);
    end
    chk("vec1.lit", 64'(rd(ids(3, 5))), {32'h11, 32'h22});

    // Forced grant after 8 waiting cycles with decode busy.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, ids(4, 6), ids(1, 2));
      expect_cycle($sformatf("force.c%0d", i), 1'b0, 1'b0, 1'b0, ids(0, 0));
    end
    step(1'b1, 1'b1, 1'b0, ids(4, 6), ids(1, 2));
    expect_cycle("force.c8", 1'b1, 1'b1, 1'b0, ids(0, 0));
    step(1'b1, 1'b0, 1'b0, ids(4, 6), ids(1, 2));
    expect_cycle("force.c9", 1'b0, 1'b0, 1'b1, ids(4, 6));
    step(1'b1, 1'b0, 1'b1, ids(4, 6), ids(1, 2));
    step(1'b0, 1'b0, 1'b0, ids(4, 6), ids(1, 2));
    expect_cycle("force.drain", 1'b0, 1'b0, 1'b0, ids(0, 0));

    // Count at limit while decode goes idle: free grant, decode not blocked.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, ids(8, 9), ids(1, 2));
    step(1'b0, 1'b1, 1'b0, ids(8, 9), ids(1, 2));
    expect_cycle("limfree", 1'b1, 1'b0, 1'b0, ids(0, 0));
    step(1'b0, 1'b0, 1'b1, ids(8, 9), ids(1, 2));
    expect_cycle("limfree.resp", 1'b0, 1'b0, 1'b1, ids(8, 9));
    step(1'b0, 1'b0, 1'b0, ids(8, 9), ids(1, 2));

    // Response backpressure with a second request pending.
    step(1'b0, 1'b1, 1'b0, ids(3, 5), ids(1, 2));
    expect_cycle("bp.grant", 1'b1, 1'b0, 1'b0, ids(0, 0));
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, ids(9, 10), ids(1, 2));
      expect_cycle($sformatf("bp.hold%0d", i), 1'b0, 1'b0, 1'b1, ids(3, 5));
      chk($sformatf("bp.lit%0d", i), 64'(bus.dbgRespData), {32'h11, 32'h22});
    end
    step(1'b0, 1'b1, 1'b1, ids(9, 10), ids(1, 2));
    expect_cycle("bp.accept", 1'b0, 1'b0, 1'b1, ids(3, 5));
    step(1'b0, 1'b1, 1'b0, ids(9, 10), ids(1, 2));
    expect_cycle("bp.regrant", 1'b1, 1'b0, 1'b0, ids(0, 0));
    step(1'b0, 1'b0, 1'b1, ids(9, 10), ids(1, 2));
    expect_cycle("bp.resp2", 1'b0, 1'b0, 1'b1, ids(9, 10));
    step(1'b0, 1'b0, 1'b0, ids(9, 10), ids(1, 2));
    expect_cycle("bp.drain", 1'b0, 1'b0, 1'b0, ids(0, 0));

    // Withdrawal at count 5 clears the counter: full 8 cycles needed after reassertion.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, ids(11, 12), ids(1, 2));
    step(1'b1, 1'b0, 1'b0, ids(11, 12), ids(1, 2));
    step(1'b1, 1'b0, 1'b0, ids(11, 12), ids(1, 2));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, ids(11, 12), ids(1, 2));
      expect_cycle($sformatf("wd.c%0d", i), 1'b0, 1'b0, 1'b0, ids(0, 0));
    end
    step(1'b1, 1'b1, 1'b0, ids(11, 12), ids(1, 2));
    expect_cycle("wd.c8", 1'b1, 1'b1, 1'b0, ids(0, 0));
    step(1'b1, 1'b0, 1'b1, ids(11, 12), ids(1, 2));
    expect_cycle("wd.resp", 1'b0, 1'b0, 1'b1, ids(11, 12));
    step(1'b0, 1'b0, 1'b0, ids(11, 12), ids(1, 2));

    // Reset while holding a response.
    step(1'b0, 1'b1, 1'b0, ids(3, 5), ids(1, 2));
    step(1'b0, 1'b1, 1'b0, ids(3, 5), ids(1, 2));
    expect_cycle("rr.resp", 1'b0, 1'b0, 1'b1, ids(3, 5));
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rr.respV",    64'(bus.dbgRespValid),  64'h0);
    chk("rr.respData", 64'(bus.dbgRespData),   64'h0);
    chk("rr.ready",    64'(bus.dbgReqReady),   64'h0);
    chk("rr.blocked",  64'(bus.decodeBlocked), 64'h0);
    chk("rr.regId",    64'(bus.regReadId),     64'(ids(1, 2)));
    bus.dbgReqValid = 1'b0;
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, ids(3, 5), ids(1, 2));
    expect_cycle("rr.after", 1'b0, 1'b0, 1'b0, ids(0, 0));

    // Reset while waiting with count 6; the count must restart from 0.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, ids(13, 14), ids(1, 2));
    expect_cycle("rw.wait", 1'b0, 1'b0, 1'b0, ids(0, 0));
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rw.ready",   64'(bus.dbgReqReady),   64'h0);
    chk("rw.blocked", 64'(bus.decodeBlocked), 64'h0);
    chk("rw.respV",   64'(bus.dbgRespValid),  64'h0);
    #1 reset = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, ids(13, 14), ids(1, 2));
      expect_cycle($sformatf("rw.c%0d", i), 1'b0, 1'b0, 1'b0, ids(0, 0));
    end
    step(1'b1, 1'b1, 1'b0, ids(13, 14), ids(1, 2));
    expect_cycle("rw.c8", 1'b1, 1'b1, 1'b0, ids(0, 0));
    step(1'b1, 1'b0, 1'b1, ids(13, 14), ids(1, 2));
    expect_cycle("rw.resp", 1'b0, 1'b0, 1'b1, ids(13, 14));
    step(1'b0, 1'b0, 1'b0, ids(13, 14), ids(1, 2));
    expect_cycle("rw.drain", 1'b0, 1'b0, 1'b0, ids(0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
